// File: rtl/priority_arbiter_rr.sv
// Request arbiter with a registered one-hot grant held until the holder signals done.
// MODE 0 grants the highest-indexed request; MODE 1 rotates priority downward from a pointer.
module priority_arbiter_rr #(
   parameter int N    = 8,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] h,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_vld,
   output logic         idle
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_ptr;
   logic [W-1:0] w_ptr_nxt;
   logic [N-1:0] r_h;
   logic [N-1:0] w_h_nxt;
   logic [W-1:0] r_gnt_idx;
   logic [W-1:0] w_idx_nxt;
   logic         r_gnt_vld;
   logic         w_vld_nxt;
   logic [W-1:0] w_win_idx;
   logic         w_win_found;

   // Search ptr, ptr-1, ... 0, N-1, ... ptr+1; in MODE 0 ptr stays at N-1,
   // which degenerates into plain highest-index-first priority.
   always_comb begin : p_search
      int pos;
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      w_win_idx   = '0;
      w_win_found = 1'b0;
      pos         = 0;
      for (int o = 0; o < N; o++) begin
         pos = (int'(r_ptr) + N - o) % N;
         if (!w_win_found && req[pos]) begin
            w_win_found = 1'b1;
            w_win_idx   = W'(pos);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_idx_nxt   = r_gnt_idx;
      w_vld_nxt   = r_gnt_vld;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_win_found) begin
               w_state_nxt = S_BUSY;
               w_h_nxt     = N'(1) << w_win_idx;
               w_idx_nxt   = w_win_idx;
               w_vld_nxt   = 1'b1;
               if (MODE == 1) begin
                  // The winner drops to lowest priority for the next round.
                  w_ptr_nxt = (w_win_idx == '0) ? W'(N - 1) : w_win_idx - W'(1);
               end
            end
         end
         S_BUSY: begin
            if (done) begin
               w_state_nxt = S_IDLE;
               w_h_nxt     = '0;
               w_idx_nxt   = '0;
               w_vld_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_h_nxt     = '0;
            w_idx_nxt   = '0;
            w_vld_nxt   = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_h       <= '0;
         r_gnt_idx <= '0;
         r_gnt_vld <= 1'b0;
         r_ptr     <= W'(N - 1);
      end else begin
         r_state   <= w_state_nxt;
         r_h       <= w_h_nxt;
         r_gnt_idx <= w_idx_nxt;
         r_gnt_vld <= w_vld_nxt;
         r_ptr     <= w_ptr_nxt;
      end
   end

   assign h       = r_h;
   assign gnt_idx = r_gnt_idx;
   assign gnt_vld = r_gnt_vld;
   assign idle    = (r_state == S_IDLE) && (req == '0);

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Bench for priority_arbiter_rr: one instance per mode, a directed vector table,
// hand-written round-robin sequences and random traffic against a reference model.
module tb_priority_arbiter_rr;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] h0, h1;
   logic [W-1:0] idx0, idx1;
   logic         vld0, vld1;
   logic         idle0, idle1;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state per mode: whether a grant is held, who holds it,
   // and where the downward search starts next time.
   bit m_busy [2];
   int m_idx  [2];
   int m_start[2];

   typedef struct {
      logic         rst_n;
      logic [N-1:0] req;
      logic         done;
      logic [N-1:0] h;
      logic [W-1:0] idx;
      logic         vld;
      logic         idle;
   } vec_t;

   vec_t vecs[16];
   int   seq_ff[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
   int   seq_81[4] = '{7, 0, 7, 0};

   priority_arbiter_rr #(.N(N), .W(W), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .h(h0), .gnt_idx(idx0), .gnt_vld(vld0), .idle(idle0)
   );

   priority_arbiter_rr #(.N(N), .W(W), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .h(h1), .gnt_idx(idx1), .gnt_vld(vld1), .idle(idle1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int start);
      for (int o = 0; o < N; o++) begin
         if (r[(start - o + N) % N]) return (start - o + N) % N;
      end
      return -1;
   endfunction

   task automatic model_update();
      int k;
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_busy[m]  = 1'b0;
            m_idx[m]   = 0;
            m_start[m] = N - 1;
         end else if (m_busy[m]) begin
            if (done) begin
               m_busy[m] = 1'b0;
               m_idx[m]  = 0;
            end
         end else if (req != '0) begin
            k         = pick(req, (m == 1) ? m_start[m] : N - 1);
            m_busy[m] = 1'b1;
            m_idx[m]  = k;
            if (m == 1) m_start[m] = (k + N - 1) % N;
         end
      end
   endtask

   task automatic model_check();
      logic [N-1:0] eh [2];
      logic         eidle [2];
      for (int m = 0; m < 2; m++) begin
         eh[m]    = m_busy[m] ? (N'(1) << m_idx[m]) : '0;
         eidle[m] = !m_busy[m] && (req == '0);
      end
      check("m0_h",    32'(h0),    32'(eh[0]));
      check("m0_idx",  32'(idx0),  32'(m_idx[0]));
      check("m0_vld",  32'(vld0),  32'(m_busy[0]));
      check("m0_idle", 32'(idle0), 32'(eidle[0]));
      check("m1_h",    32'(h1),    32'(eh[1]));
      check("m1_idx",  32'(idx1),  32'(m_idx[1]));
      check("m1_vld",  32'(vld1),  32'(m_busy[1]));
      check("m1_idle", 32'(idle1), 32'(eidle[1]));
   endtask

   // Advance one edge, update the model with the inputs the DUT sampled,
   // then compare just after the edge.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      for (int m = 0; m < 2; m++) begin
         m_busy[m]  = 1'b0;
         m_idx[m]   = 0;
         m_start[m] = N - 1;
      end

      //            rst_n  req    done  h      idx   vld   idle
      vecs[0]  = '{1'b0, 8'hA5, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 8'hA5, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 8'h3C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 8'h3C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

      // Directed MODE 0 table: reset, hold against req changes, done release, mid-grant reset.
      for (int i = 0; i < 16; i++) begin
         rst_n = vecs[i].rst_n;
         req   = vecs[i].req;
         done  = vecs[i].done;
         tick();
         check($sformatf("vec%0d_h", i),    32'(h0),    32'(vecs[i].h));
         check($sformatf("vec%0d_idx", i),  32'(idx0),  32'(vecs[i].idx));
         check($sformatf("vec%0d_vld", i),  32'(vld0),  32'(vecs[i].vld));
         check($sformatf("vec%0d_idle", i), 32'(idle0), 32'(vecs[i].idle));
      end

      // Round-robin over all requesters, with a gap cycle between grants.
      reset_dut();
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("rr_ff_idx%0d", i), 32'(idx1), 32'(seq_ff[i]));
         check($sformatf("rr_ff_vld%0d", i), 32'(vld1), 32'd1);
         done = 1'b1;
         tick();
         check($sformatf("rr_ff_gap%0d", i), 32'(h1), 32'd0);
         done = 1'b0;
      end

      // Two requesters at the extremes alternate.
      reset_dut();
      req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr_81_idx%0d", i), 32'(idx1), 32'(seq_81[i]));
         done = 1'b1;
         tick();
         done = 1'b0;
      end

      // Reset while busy restores the pointer.
      reset_dut();
      req = 8'hFF;
      tick();
      check("rst_busy_g7", 32'(idx1), 32'd7);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check("rst_busy_g6", 32'(idx1), 32'd6);
      rst_n = 1'b0;
      tick();
      check("rst_busy_h",   32'(h1),   32'd0);
      check("rst_busy_vld", 32'(vld1), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_busy_after", 32'(idx1), 32'd7);

      // Random traffic against the model.
      reset_dut();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = N'($urandom) & N'($urandom) & N'($urandom);
            default: req = N'($urandom);
         endcase
         done  = ($urandom_range(0, 2) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/priority_arbiter_rr.md
PRIORITY_ARBITER_RR -- requirements
Module: priority_arbiter_rr

Interface
REQ-001: The block SHALL have parameter N, default 8, giving the number of requesters (legal range 2..32).
REQ-002: The block SHALL have parameter W, default $clog2(N), giving the grant index width.
REQ-003: The block SHALL have parameter MODE, default 0, selecting arbitration mode (0 = fixed priority, 1 = round-robin).
REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005: The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006: The block SHALL have port req, input, N bits: request vector, one bit per requester.
REQ-007: The block SHALL have port done, input, 1 bit: the current grant holder releases its grant.
REQ-008: The block SHALL have port h, output, N bits: registered one-hot grant vector.
REQ-009: The block SHALL have port gnt_idx, output, W bits: registered binary index of the granted requester.
REQ-010: The block SHALL have port gnt_vld, output, 1 bit: registered; high while a grant is held.
REQ-011: The block SHALL have port idle, output, 1 bit: high when no grant is held and req is all zero.

Function
REQ-012: The FSM SHALL have two states: IDLE (no grant held) and BUSY (grant held).
REQ-013: In IDLE with req != 0, the FSM SHALL select a winner, go to BUSY, and register h, gnt_idx and gnt_vld = 1 on the same edge (1-cycle latency from req to grant).
REQ-014: In IDLE with req == 0, the FSM SHALL stay in IDLE, with h = 0, gnt_idx = 0 and gnt_vld = 0.
REQ-015: MODE 0 SHALL grant the highest-indexed asserted req bit (bit N-1 has highest priority).
REQ-016: MODE 1 SHALL keep a W-bit pointer ptr; the search order is ptr, ptr-1, ... down to 0, then wraps to N-1 ... ptr+1.
REQ-017: In MODE 1, on granting index k, ptr SHALL update to (k-1) mod N, so k becomes lowest priority; wrap is 0 -> N-1.
REQ-018: In MODE 0, ptr SHALL be held at N-1 and have no effect.
REQ-019: In BUSY with done = 0, h, gnt_idx and gnt_vld SHALL hold unchanged, even if req changes or the granted req bit drops.
REQ-020: In BUSY with done = 1, the FSM SHALL return to IDLE and clear h, gnt_idx and gnt_vld on that edge; the next grant appears at the earliest one cycle later, so consecutive grants are separated by at least one cycle with h = 0.
REQ-021: done SHALL be ignored in IDLE.
REQ-022: h SHALL always be zero or one-hot, and gnt_idx SHALL always equal the position of the set bit in h (0 when h = 0).
REQ-023: idle SHALL be combinational: (state == IDLE) & (req == 0).

Reset
REQ-024: When rst_n = 0 at a rising clk edge, the block SHALL set state = IDLE, h = 0, gnt_idx = 0, gnt_vld = 0 and ptr = N-1, regardless of req and done, including mid-grant.
REQ-025: Reset SHALL take precedence over every other transition, and the first arbitration after reset in MODE 1 SHALL match MODE 0.

Verification (N = 8)
REQ-026: MODE 0, req = 8'hA5 in IDLE -> next cycle h = 8'h80, gnt_idx = 7, gnt_vld = 1, idle = 0.
REQ-027: Grant held, req changed to 8'h01 with done = 0 for 5 cycles -> h unchanged; done pulse -> h = 0 for one cycle, then h = 8'h01, gnt_idx = 0.
REQ-028: MODE 1, req = 8'hFF constant, done pulsed once per grant -> gnt_idx sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, with an h = 0 cycle between grants.
REQ-029: MODE 1, req = 8'h81 constant, done per grant -> gnt_idx alternates 7, 0, 7, 0.
REQ-030: MODE 1, after grants 7 and 6, rst_n low for one cycle during the BUSY state -> h = 0, gnt_vld = 0; then req = 8'hFF -> gnt_idx = 7 (ptr reset).
REQ-031: After reset with req = 0 and done = 1 held -> idle = 1, h = 0, gnt_vld = 0 on every cycle.
